// File: rtl/bp_trigger_csr_if.sv
// CSR read/write port between the CSR file (master) and the trigger CSR block (slave).
interface bp_trigger_csr_if;
  logic [11:0] io_rw_addr;
  logic [2:0]  io_rw_cmd;
  logic [31:0] io_rw_wdata;
  logic [31:0] io_rw_rdata;
  logic        io_rw_hit;

  modport master (
    output io_rw_addr,
    output io_rw_cmd,
    output io_rw_wdata,
    input  io_rw_rdata,
    input  io_rw_hit
  );

  modport slave (
    input  io_rw_addr,
    input  io_rw_cmd,
    input  io_rw_wdata,
    output io_rw_rdata,
    output io_rw_hit
  );
endinterface

// File: rtl/bp_trigger_csr.sv
// Single debug trigger CSR state (tselect/tdata1/tdata2) with mcontrol write
// legalisation, driving the control/address bundle of the breakpoint unit.
module bp_trigger_csr #(
  parameter int XLEN    = 32,
  parameter int MASKMAX = 4,
  parameter int HAS_H   = 0
) (
  input  logic                clock,
  input  logic                reset,
  bp_trigger_csr_if.slave     rw,
  input  logic                io_status_debug,
  output logic [3:0]          io_bp_0_control_ttype,
  output logic                io_bp_0_control_dmode,
  output logic [5:0]          io_bp_0_control_maskmax,
  output logic [7:0]          io_bp_0_control_reserved,
  output logic                io_bp_0_control_action,
  output logic                io_bp_0_control_chain,
  output logic [1:0]          io_bp_0_control_zero,
  output logic [1:0]          io_bp_0_control_tmatch,
  output logic                io_bp_0_control_m,
  output logic                io_bp_0_control_h,
  output logic                io_bp_0_control_s,
  output logic                io_bp_0_control_u,
  output logic                io_bp_0_control_x,
  output logic                io_bp_0_control_w,
  output logic                io_bp_0_control_r,
  output logic [XLEN-1:0]     io_bp_0_address
);

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
  localparam logic [3:0]  TTYPE_MCTRL  = 4'd2;
  localparam logic [5:0]  MASKMAX_C    = 6'(MASKMAX);
  localparam logic        HAS_H_C      = (HAS_H != 0) ? 1'b1 : 1'b0;

  // Read-modify-write operand selection for write/set/clear commands.
  function automatic logic [31:0] csr_write_value(
    input logic [2:0]  cmd,
    input logic [31:0] rdata,
    input logic [31:0] wdata
  );
    logic [31:0] v;
    case (cmd)
      3'd6:    v = rdata | wdata;
      3'd7:    v = rdata & ~wdata;
      default: v = wdata;
    endcase
    return v;
  endfunction

  logic        r_dmode;
  logic        r_action;
  logic [1:0]  r_tmatch;
  logic        r_m;
  logic        r_h;
  logic        r_s;
  logic        r_u;
  logic        r_x;
  logic        r_w;
  logic        r_r;
  logic [31:0] r_address;

  logic [31:0] w_tdata1;
  logic [31:0] w_rdata;
  logic        w_hit;
  logic        w_is_write_cmd;
  logic        w_locked;
  logic        w_wen;
  logic [31:0] w_wv;
  logic        w_dmode_n;

  // tdata1 as seen by software: constant fields merged with held state.
  assign w_tdata1 = {TTYPE_MCTRL, r_dmode, MASKMAX_C, 8'd0, r_action, 1'b0, 2'b00,
                     r_tmatch, r_m, r_h, r_s, r_u, r_x, r_w, r_r};

  // Address decode and combinational read data.
  always_comb begin
    w_rdata = 32'd0;
    w_hit   = 1'b0;
    case (rw.io_rw_addr)
      ADDR_TSELECT: begin
        w_rdata = 32'd0;
        w_hit   = 1'b1;
      end
      ADDR_TDATA1: begin
        w_rdata = w_tdata1;
        w_hit   = 1'b1;
      end
      ADDR_TDATA2: begin
        w_rdata = r_address;
        w_hit   = 1'b1;
      end
      default: begin
        w_rdata = 32'd0;
        w_hit   = 1'b0;
      end
    endcase
  end

  assign rw.io_rw_rdata = w_rdata;
  assign rw.io_rw_hit   = w_hit;

  // Write qualification: only write/set/clear to a decoded address, and a
  // debug-mode-owned trigger cannot be touched from outside debug mode.
  always_comb begin
    w_is_write_cmd = 1'b0;
    case (rw.io_rw_cmd)
      3'd5, 3'd6, 3'd7: w_is_write_cmd = 1'b1;
      default:          w_is_write_cmd = 1'b0;
    endcase
  end

  assign w_locked  = r_dmode & ~io_status_debug;
  assign w_wen     = w_is_write_cmd & w_hit;
  assign w_wv      = csr_write_value(rw.io_rw_cmd, w_rdata, rw.io_rw_wdata);
  assign w_dmode_n = w_wv[27] & io_status_debug;

  // Trigger state update; reset takes priority over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dmode   <= 1'b0;
      r_action  <= 1'b0;
      r_tmatch  <= 2'b00;
      r_m       <= 1'b0;
      r_h       <= 1'b0;
      r_s       <= 1'b0;
      r_u       <= 1'b0;
      r_x       <= 1'b0;
      r_w       <= 1'b0;
      r_r       <= 1'b0;
      r_address <= 32'd0;
    end else if (w_wen && !w_locked) begin
      case (rw.io_rw_addr)
        ADDR_TDATA1: begin
          r_dmode  <= w_dmode_n;
          r_action <= w_wv[12] & w_dmode_n;
          r_tmatch <= w_wv[8:7];
          r_m      <= w_wv[6];
          r_h      <= w_wv[5] & HAS_H_C;
          r_s      <= w_wv[4];
          r_u      <= w_wv[3];
          r_x      <= w_wv[2];
          r_w      <= w_wv[1];
          r_r      <= w_wv[0];
        end
        ADDR_TDATA2: begin
          r_address <= w_wv;
        end
        default: begin
          // tselect has a single legal value; nothing to store.
          r_address <= r_address;
        end
      endcase
    end else begin
      r_address <= r_address;
    end
  end

  assign io_bp_0_control_ttype    = TTYPE_MCTRL;
  assign io_bp_0_control_dmode    = r_dmode;
  assign io_bp_0_control_maskmax  = MASKMAX_C;
  assign io_bp_0_control_reserved = 8'd0;
  assign io_bp_0_control_action   = r_action;
  assign io_bp_0_control_chain    = 1'b0;
  assign io_bp_0_control_zero     = 2'b00;
  assign io_bp_0_control_tmatch   = r_tmatch;
  assign io_bp_0_control_m        = r_m;
  assign io_bp_0_control_h        = r_h;
  assign io_bp_0_control_s        = r_s;
  assign io_bp_0_control_u        = r_u;
  assign io_bp_0_control_x        = r_x;
  assign io_bp_0_control_w        = r_w;
  assign io_bp_0_control_r        = r_r;
  assign io_bp_0_address          = r_address;

endmodule

// File: tb/tb_bp_trigger_csr.sv
// Self-checking bench for bp_trigger_csr: word-level reference model compared
// every cycle, plus directed literal expectations that pin the model.
module tb_bp_trigger_csr;
  localparam int MASKMAX = 4;

  logic clock;
  logic reset;
  logic io_status_debug;
  logic [3:0]  ttype;
  logic        dmode;
  logic [5:0]  maskmax;
  logic [7:0]  reserved;
  logic        action;
  logic        chain;
  logic [1:0]  zero;
  logic [1:0]  tmatch;
  logic        bm, bh, bs, bu, bx, bw, br;
  logic [31:0] address;

  bp_trigger_csr_if rw_if ();

  bp_trigger_csr #(.XLEN(32), .MASKMAX(MASKMAX), .HAS_H(0)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .rw                       (rw_if.slave),
    .io_status_debug          (io_status_debug),
    .io_bp_0_control_ttype    (ttype),
    .io_bp_0_control_dmode    (dmode),
    .io_bp_0_control_maskmax  (maskmax),
    .io_bp_0_control_reserved (reserved),
    .io_bp_0_control_action   (action),
    .io_bp_0_control_chain    (chain),
    .io_bp_0_control_zero     (zero),
    .io_bp_0_control_tmatch   (tmatch),
    .io_bp_0_control_m        (bm),
    .io_bp_0_control_h        (bh),
    .io_bp_0_control_s        (bs),
    .io_bp_0_control_u        (bu),
    .io_bp_0_control_x        (bx),
    .io_bp_0_control_w        (bw),
    .io_bp_0_control_r        (br),
    .io_bp_0_address          (address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tdata1 kept as the full software-visible word.
  localparam logic [31:0] T1_RESET = 32'h2000_0000 | (32'(MASKMAX) << 21);
  localparam logic [31:0] T1_PLAIN = 32'h0000_01DF; // tmatch,m,s,u,x,w,r
  logic [31:0] m_t1;
  logic [31:0] m_t2;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h7A1) return m_t1;
    else if (a == 12'h7A2) return m_t2;
    else return 32'd0;
  endfunction

  function automatic logic model_hit(input logic [11:0] a);
    return (a >= 12'h7A0) && (a <= 12'h7A2);
  endfunction

  always @(posedge clock) begin
    logic [31:0] cur, wv;
    logic        dm, act;
    if (reset) begin
      m_t1 = T1_RESET;
      m_t2 = 32'd0;
      model_valid = 1'b1;
    end else if (model_valid && model_hit(rw_if.io_rw_addr) &&
                 (rw_if.io_rw_cmd == 3'd5 || rw_if.io_rw_cmd == 3'd6 || rw_if.io_rw_cmd == 3'd7) &&
                 !(m_t1[27] && !io_status_debug)) begin
      cur = model_read(rw_if.io_rw_addr);
      if (rw_if.io_rw_cmd == 3'd5) wv = rw_if.io_rw_wdata;
      else if (rw_if.io_rw_cmd == 3'd6) wv = cur | rw_if.io_rw_wdata;
      else wv = cur & ~rw_if.io_rw_wdata;
      if (rw_if.io_rw_addr == 12'h7A1) begin
        dm  = wv[27] && io_status_debug;
        act = wv[12] && dm;
        m_t1 = T1_RESET | (wv & T1_PLAIN) | (dm ? 32'h0800_0000 : 32'd0) | (act ? 32'h0000_1000 : 32'd0);
      end else if (rw_if.io_rw_addr == 12'h7A2) begin
        m_t2 = wv;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [31:0] ctl;
    if (model_valid) begin
      ctl = {ttype, dmode, maskmax, reserved, action, chain, zero, tmatch, bm, bh, bs, bu, bx, bw, br};
      check32("rdata", rw_if.io_rw_rdata, model_read(rw_if.io_rw_addr));
      check32("hit", {31'd0, rw_if.io_rw_hit}, {31'd0, model_hit(rw_if.io_rw_addr)});
      check32("control", ctl, m_t1);
      check32("address", address, m_t2);
    end
  end

  task automatic drive(input logic [11:0] a, input logic [2:0] c, input logic [31:0] d,
                       input logic dbg, input logic rst);
    @(posedge clock);
    #2;
    rw_if.io_rw_addr  = a;
    rw_if.io_rw_cmd   = c;
    rw_if.io_rw_wdata = d;
    io_status_debug   = dbg;
    reset             = rst;
  endtask

  initial begin
    reset = 1'b1;
    io_status_debug = 1'b0;
    rw_if.io_rw_addr  = 12'h000;
    rw_if.io_rw_cmd   = 3'd0;
    rw_if.io_rw_wdata = 32'd0;
    drive(12'h000, 3'd0, 32'd0, 1'b0, 1'b1);
    drive(12'h000, 3'd0, 32'd0, 1'b0, 1'b1);

    // Reset state
    drive(12'h7A1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_reset_tdata1", rw_if.io_rw_rdata, 32'h2080_0000);
    check32("lit_reset_ttype", {28'd0, ttype}, 32'd2);
    check32("lit_reset_maskmax", {26'd0, maskmax}, 32'd4);
    check32("lit_reset_addr", address, 32'd0);

    // Plain write, debug=0
    drive(12'h7A1, 3'd5, 32'h0000_1187, 1'b0, 1'b0);
    drive(12'h7A1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_wr_tdata1", rw_if.io_rw_rdata, 32'h2080_0187);
    check32("lit_wr_fields", {26'd0, tmatch, action, bh, bx, bw, br}, {26'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});

    // h is hardwired, dmode needs debug
    drive(12'h7A1, 3'd5, 32'h0800_1020, 1'b0, 1'b0);
    drive(12'h7A1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_h_dmode_gated", rw_if.io_rw_rdata, 32'h2080_0000);

    // dmode write from debug, then lock
    drive(12'h7A1, 3'd5, 32'h0800_1001, 1'b1, 1'b0);
    drive(12'h7A1, 3'd2, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    check32("lit_dmode_tdata1", rw_if.io_rw_rdata, 32'h2880_1001);
    drive(12'h7A2, 3'd5, 32'h0000_1234, 1'b0, 1'b0);
    drive(12'h7A1, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive(12'h7A2, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_locked_addr", address, 32'd0);
    drive(12'h7A1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_locked_tdata1", rw_if.io_rw_rdata, 32'h2880_1001);

    // Unlock from debug mode
    drive(12'h7A1, 3'd5, 32'd0, 1'b1, 1'b0);
    drive(12'h7A1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_unlock_tdata1", rw_if.io_rw_rdata, 32'h2080_0000);

    // Back-to-back write then set, then clear
    drive(12'h7A2, 3'd5, 32'h8000_0010, 1'b0, 1'b0);
    drive(12'h7A2, 3'd6, 32'h0000_000F, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_b2b_first", address, 32'h8000_0010);
    drive(12'h7A2, 3'd7, 32'h8000_0000, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_b2b_set", address, 32'h8000_001F);
    drive(12'h7A2, 3'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check32("lit_b2b_clear", address, 32'h0000_001F);

    // Non-writing commands and unmapped address
    drive(12'h7A1, 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive(12'h7A1, 3'd4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive(12'h7A3, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clock);
    check32("lit_7a3_hit", {31'd0, rw_if.io_rw_hit}, 32'd0);
    drive(12'h7A0, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clock);
    check32("lit_tselect", {rw_if.io_rw_rdata[30:0], rw_if.io_rw_hit}, 32'd1);
    drive(12'h7A1, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clock);
    check32("lit_nochange", rw_if.io_rw_rdata, 32'h2080_0000);

    // Reset beats a simultaneous write
    drive(12'h7A2, 3'd5, 32'h5555_AAAA, 1'b0, 1'b0);
    drive(12'h7A1, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drive(12'h7A1, 3'd2, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    check32("lit_rst_wins_t1", rw_if.io_rw_rdata, 32'h2080_0000);
    check32("lit_rst_wins_addr", address, 32'd0);

    drive(12'h000, 3'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_trigger_csr.md
Name: bp_trigger_csr

Overview:
- Holds the single debug trigger's tselect/tdata1/tdata2 CSR state for the RV32 core and drives the `io_bp_0_*` control/address bundle consumed directly by the breakpoint match unit.
- Sits between the CSR read/write port of the CSR file and the breakpoint unit.
- Applies the mcontrol write-legalisation rules: dmode lock, action gating, and hardwired fields.
- Writes take effect one cycle after the command.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MASKMAX, 4, constant value driven on `io_bp_0_control_maskmax`.
- HAS_H, 0, when 0 the h bit is hardwired to 0.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- io_rw_addr  in  12  CSR address
- io_rw_cmd  in  3  0 none, 2 read, 4 ignored, 5 write, 6 set, 7 clear
- io_rw_wdata  in  32  CSR write operand
- io_rw_rdata  out  32  read data for io_rw_addr, combinational
- io_rw_hit  out  1  io_rw_addr is 0x7A0, 0x7A1 or 0x7A2
- io_status_debug  in  1  core is in debug mode
- io_bp_0_control_ttype  out  4  constant 2
- io_bp_0_control_dmode  out  1
- io_bp_0_control_maskmax  out  6  constant MASKMAX
- io_bp_0_control_reserved  out  8  constant 0
- io_bp_0_control_action  out  1
- io_bp_0_control_chain  out  1  constant 0
- io_bp_0_control_zero  out  2  constant 0
- io_bp_0_control_tmatch  out  2
- io_bp_0_control_m / _h / _s / _u / _x / _w / _r  out  1 each
- io_bp_0_address  out  32  tdata2

Behaviour:
- Register state: dmode, action, tmatch[1:0], m, h, s, u, x, w, r, address[31:0]. All other bundle fields are constants.
- Reset: all register state is 0. Outputs after reset:
  - ttype = 2, maskmax = MASKMAX, all other control fields 0.
  - address = 0.
  - io_rw_rdata = 0 for all addresses except 0x7A1, which reads 0x2000_0000 | MASKMAX<<21.
- Reset wins over any write in the same cycle.
- tdata1 read layout:
  - [31:28] ttype, [27] dmode, [26:21] maskmax, [20:13] 0
  - [12] action, [11] chain, [10:9] 0, [8:7] tmatch
  - [6] m, [5] h, [4] s, [3] u, [2] x, [1] w, [0] r
- Read data by address:
  - 0x7A0 (tselect) reads 0.
  - 0x7A2 reads the address register.
  - Any other address reads 0 and io_rw_hit = 0.
- Write enable: io_rw_cmd in {5, 6, 7} and io_rw_hit.
  - Commands 0, 2 and 4 never modify state.
- Write value wv, computed from io_rw_rdata in the same cycle:
  - cmd 5: wv = wdata
  - cmd 6: wv = rdata | wdata
  - cmd 7: wv = rdata & ~wdata
- Lock: if the current dmode = 1 and io_status_debug = 0, writes to 0x7A1 and 0x7A2 are dropped entirely.
- tdata1 legalisation on an accepted write:
  - dmode_n = wv[27] & io_status_debug
  - action_n = wv[12] & dmode_n
  - h_n = wv[5] & HAS_H
  - tmatch, m, s, u, x, w, r are taken directly from wv.
  - ttype, maskmax, chain, reserved and zero are ignored (read-only).
- tdata2: an accepted write loads all 32 bits of wv.
- tselect: writes are accepted but have no effect, since there is only one trigger.
- Latency: an accepted write at cycle N appears on io_bp_0_* and io_rw_rdata at cycle N+1. No bypass of the write value to the outputs.
- Back-to-back writes, one per cycle, are all applied in order.
  - A set/clear in the cycle after a write uses the already-updated value.

Test Plan:
- Reset, then read 0x7A1 -> rdata 0x2080_0000 (MASKMAX=4); all io_bp_0_* fields 0 except ttype=2, maskmax=4; address 0.
- cmd 5 to 0x7A1 with wdata 0x0000_1187, debug=0 -> next cycle: tmatch=3, x=1, w=1, r=1, action=0 (dmode 0), h=0, rdata 0x2080_0187.
- debug=1, cmd 5 to 0x7A1 with wdata 0x0800_1001 -> dmode=1, action=1, r=1. Then debug=0, cmd 5 to 0x7A2 with wdata 0x1234 -> address unchanged at 0; cmd 7 to 0x7A1 is also dropped.
- cmd 5 to 0x7A2 with wdata 0x8000_0010, then cmd 6 with wdata 0x0F -> address 0x8000_0010, then 0x8000_001F on consecutive cycles.
- cmd 2 and cmd 4 to 0x7A1, and cmd 5 to 0x7A3 -> no state change; io_rw_hit = 0 for 0x7A3.
- cmd 5 to 0x7A1 with wdata 0xFFFF_FFFF asserted together with reset -> state stays at reset values.
